// File: rtl/ram_seq_ctrl.sv
// Fills a single-port sync RAM with mem[i] = mem[i-2] + mem[i-1], then streams the table out on result.
// Define RAM_SEQ_SAT_EN to saturate the sum to all ones on carry-out instead of wrapping.
module ram_seq_ctrl #(
   parameter int                ADDR_W = 6,
   parameter int                DATA_W = 32,
   parameter int                N      = 64,
   parameter logic [DATA_W-1:0] SEED0  = DATA_W'(1),
   parameter logic [DATA_W-1:0] SEED1  = DATA_W'(1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT0,
      S_INIT1,
      S_RD_A,
      S_RD_B,
      S_WR,
      S_DUMP,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N - 1);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W:0]   i;
   logic [ADDR_W:0]   j;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] sum;
   logic              dump_q;
   logic              done_d;
   logic              busy_d;

`ifdef RAM_SEQ_SAT_EN
   logic [DATA_W:0] sum_full;

   always_comb begin
      sum_full = {1'b0, a_reg} + {1'b0, ram_dout};
      sum      = sum_full[DATA_W] ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
   end
`else
   always_comb begin
      sum = a_reg + ram_dout;
   end
`endif

   always_comb begin
      next_state = state;
      ram_addr   = '0;
      ram_din    = '0;
      ram_we     = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) next_state = S_INIT0;
         end
         S_INIT0: begin
            ram_din    = SEED0;
            ram_we     = 1'b1;
            next_state = S_INIT1;
         end
         S_INIT1: begin
            ram_addr   = ADDR_W'(1);
            ram_din    = SEED1;
            ram_we     = 1'b1;
            next_state = S_RD_A;
         end
         S_RD_A: begin
            ram_addr   = ADDR_W'(i - TWO);
            next_state = S_RD_B;
         end
         S_RD_B: begin
            ram_addr   = ADDR_W'(i - ONE);
            next_state = S_WR;
         end
         S_WR: begin
            // ram_dout here is mem[i-1], read by the address issued in RD_B
            ram_addr   = ADDR_W'(i);
            ram_din    = sum;
            ram_we     = 1'b1;
            next_state = (i == LAST) ? S_DUMP : S_RD_A;
         end
         S_DUMP: begin
            ram_addr = ADDR_W'(j);
            if (j == LAST) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            next_state = S_DONE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // done/busy lag the state by one cycle so they change together, after the last result word
   always_comb begin
      done_d = (state == S_DONE) && !start;
      busy_d = (next_state != S_IDLE) && !done_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         i     <= '0;
         j     <= '0;
         a_reg <= '0;
      end else begin
         state <= next_state;
         case (state)
            S_INIT1: i <= TWO;
            S_RD_B:  a_reg <= ram_dout;
            S_WR: begin
               if (i == LAST) j <= '0;
               else           i <= i + ONE;
            end
            S_DUMP: begin
               if (j != LAST) j <= j + ONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dump_q       <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         dump_q       <= (state == S_DUMP);
         result_valid <= dump_q;
         if (dump_q) result <= ram_dout;
         busy         <= busy_d;
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Randomized bench for ram_seq_ctrl against a table model; honours RAM_SEQ_SAT_EN for the expected sums.
module tb_ram_seq_ctrl;

   localparam int          AW = 3;
   localparam int          DW = 32;
   localparam int          NW = 8;
   localparam logic [31:0] S0 = 32'hFFFF_FFFF;
   localparam logic [31:0] S1 = 32'h0000_0002;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;
   logic [DW-1:0] result;
   logic          result_valid;
   logic          busy;
   logic          done;

   logic [DW-1:0] mem [0:NW-1];
   logic [DW-1:0] exp_w [0:NW-1];
   int            n_chk;
   int            n_err;

   ram_seq_ctrl #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .N      (NW),
      .SEED0  (S0),
      .SEED1  (S1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din),
      .ram_we       (ram_we),
      .ram_dout     (ram_dout),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic build_model();
      logic [63:0] s;
      exp_w[0] = S0;
      exp_w[1] = S1;
      for (int k = 2; k < NW; k++) begin
         s = {32'h0, exp_w[k-2]} + {32'h0, exp_w[k-1]};
`ifdef RAM_SEQ_SAT_EN
         exp_w[k] = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
         exp_w[k] = s[31:0];
`endif
      end
   endtask

   // Junk in the RAM proves that every word is written by the fill
   task automatic scramble();
      @(negedge clk);
      for (int a = 0; a < NW; a++) mem[a] <= $urandom;
   endtask

   task automatic run_seq(input int extra_k);
      int   we_cnt;
      logic ev;
      we_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 4*NW+1; k++) begin
         @(negedge clk);
         start = (k == extra_k);
         ev = (k >= 3*NW-1) && (k <= 4*NW-2);
         chk("result_valid", 32'(result_valid), 32'(ev));
         if (ev) chk("result", result, exp_w[k-(3*NW-1)]);
         chk("done", 32'(done), 32'(k >= 4*NW-1));
         chk("busy", 32'(busy), 32'(k <= 4*NW-2));
         if (ram_we) we_cnt++;
      end
      chk("we_count", 32'(we_cnt), 32'(NW));
   endtask

   task automatic reset_mid();
      int            r;
      logic [AW-1:0] wa;
      logic [DW-1:0] old;
      r = 5 + 3*int'($urandom_range(0, NW-3));
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= r; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("we_in_wr", 32'(ram_we), 32'd1);
      wa  = ram_addr;
      old = mem[wa];
      rst = 1'b1;
      #1;
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_din", ram_din, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("no_write_on_rst", mem[wa], old);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      start = 1'b0;
      build_model();
      repeat (3) @(negedge clk);
      chk("reset_addr", 32'(ram_addr), 32'd0);
      chk("reset_din", ram_din, 32'd0);
      chk("reset_we", 32'(ram_we), 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_rv", 32'(result_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      rst = 1'b0;
      scramble();
      run_seq(0);
      run_seq(0);
      run_seq(5);
      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         scramble();
         run_seq(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4*NW-3)));
      end
      reset_mid();
      scramble();
      run_seq(0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
